// File: rtl/buffer_pkg.sv
// buffer_pkg: FSM state encodings and shared widths for buffer_reader
package buffer_pkg;
  localparam int DROP_W = 8;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_e;
endpackage

// File: rtl/lane_packer.sv
// lane_packer: N payload lanes of W bits with indexed write and bulk clear; lane 0 in the LSBs
module lane_packer #(
  parameter int W  = 15,
  parameter int N  = 2,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic          clr_i,
  input  logic [IW-1:0] idx_i,
  input  logic [W-1:0]  din_i,
  output logic [N*W-1:0] data_o
);
  logic [N*W-1:0] data_q;
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) data_q <= '0;
    else if (clr_i) data_q <= '0;
    else if (we_i)
      for (int i = 0; i < N; i++)
        if (idx_i == IW'(i)) data_q[i*W +: W] <= din_i;
  assign data_o = data_q;
endmodule

// File: rtl/buffer_reader.sv
// buffer_reader: pops words from an upstream buffer and packs pack valid payloads per output word.
// Define BUFFER_READER_PARITY_EN to add the registered out_parity output.
module buffer_reader
  import buffer_pkg::*;
#(
  parameter int bit_width = 16,
  parameter int pack      = 2,
  parameter int wait_max  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          empty,
  input  logic [bit_width-1:0]          data_in,
  output logic                          consume,
  output logic [pack*(bit_width-1)-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DROP_W-1:0]             drop_cnt
`ifdef BUFFER_READER_PARITY_EN
  ,
  output logic                          out_parity
`endif
);
  localparam int W  = bit_width - 1;
  localparam int IW = $clog2(pack + 1);
  localparam int CW = $clog2(wait_max + 1);
  localparam logic [IW-1:0] PACK_V = IW'(pack);
  localparam logic [CW-1:0] WMAX_V = CW'(wait_max);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic valid, we, clr;
  assign valid = data_in[bit_width-1];
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    we      = 1'b0;
    clr     = 1'b0;
    consume = 1'b0;
    case (state_q)
      IDLE: state_d = empty ? IDLE : REQ;
      // a pop is never issued into an empty buffer; fall back and retry
      REQ: begin
        consume = !empty;
        cnt_d   = '0;
        state_d = empty ? IDLE : WAIT;
      end
      WAIT:
        if (valid) begin
          we      = 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = (idx_d == PACK_V) ? OUT : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == WMAX_V) begin
            drop_d  = drop_q + DROP_W'(drop_q != '1);
            state_d = IDLE;
          end
        end
      OUT:
        if (out_ready) begin
          clr     = 1'b1;
          idx_d   = '0;
          state_d = empty ? IDLE : REQ;
        end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  lane_packer #(.W(W), .N(pack), .IW(IW)) u_lanes (
    .clk    (clk),
    .rst_n_i(rst),
    .we_i   (we),
    .clr_i  (clr),
    .idx_i  (idx_q),
    .din_i  (data_in[W-1:0]),
    .data_o (out_data)
  );
  assign out_valid = state_q == OUT;
  assign drop_cnt  = drop_q;
`ifdef BUFFER_READER_PARITY_EN
  logic par_q, par_d;
  // parity accumulates lane by lane so it lands together with the last lane
  assign par_d = clr ? 1'b0 : we ? par_q ^ (^data_in[W-1:0]) : par_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) par_q <= 1'b0;
    else par_q <= par_d;
  assign out_parity = par_q;
`endif
endmodule

// File: tb/tb_buffer_reader.sv
// tb_buffer_reader: scenario tasks plus an upstream-buffer responder and packed-word reference model
module tb_buffer_reader;
  localparam int BW = 16, PACK = 2, WAIT_MAX = 3, W = BW - 1;
  typedef logic [PACK*W-1:0] word_t;
  logic clk = 1'b0, rst = 1'b0, empty = 1'b1, out_ready = 1'b0;
  logic consume, out_valid;
  logic [BW-1:0] data_in;
  word_t out_data;
  logic [7:0] drop_cnt;
`ifdef BUFFER_READER_PARITY_EN
  logic out_parity;
`endif
  int checks = 0, passed = 0;
  bit act = 0, exp_ov = 0, force_drop = 0;
  int k = 0, d = 0, lanes = 0, exp_drop = 0, n_cons = 0, words_done = 0;
  logic [W-1:0] p;
  word_t cur;
  word_t exp_words[$];
  int dq[$];
  logic [W-1:0] pq[$];

  always #5 clk = ~clk;

  buffer_reader #(.bit_width(BW), .pack(PACK), .wait_max(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .empty(empty), .data_in(data_in), .consume(consume),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
`ifdef BUFFER_READER_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  // Upstream buffer: answers each pop after d cycles; d >= WAIT_MAX means the word never shows up
  always @(negedge clk) begin
    if (!rst) begin
      act = 0; k = 0; lanes = 0; cur = '0; exp_ov = 0; exp_drop = 0; data_in = '0;
      exp_words.delete();
    end else begin
      if (exp_ov && out_ready) begin
        void'(exp_words.pop_front());
        exp_ov = 0;
      end
      if (act) begin
        if (k == d) begin
          data_in = {1'b1, p};
          cur[lanes*W +: W] = p;
          lanes++;
          act = 0;
          if (lanes == PACK) begin
            exp_words.push_back(cur);
            cur = '0; lanes = 0; exp_ov = 1; words_done++;
          end
        end else begin
          data_in = {1'b0, W'($urandom)};
          if (k == WAIT_MAX - 1) begin
            act = 0;
            if (exp_drop < 255) exp_drop++;
          end
        end
        k++;
      end else data_in = BW'($urandom);
      if (consume) begin
        act = 1; k = 0; n_cons++;
        if (dq.size() > 0) begin
          d = dq.pop_front();
          p = pq.pop_front();
        end else begin
          d = force_drop ? WAIT_MAX : $urandom_range(0, WAIT_MAX);
          p = W'($urandom);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    cyc(); empty = 1; out_ready = 1;
    repeat (8) cyc();
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0; empty = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (consume !== 1'b0) $display("FAIL reset_consume got %b want 0", consume); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else passed++;
    checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); else passed++;
`ifdef BUFFER_READER_PARITY_EN
    checks++; if (out_parity !== 1'b0) $display("FAIL reset_parity got %b want 0", out_parity); else passed++;
`endif
    cyc(); rst = 1; empty = 1; out_ready = 0;
  endtask

  task automatic test_basic();
    int n0;
    bit ok;
    n0 = n_cons;
    dq.push_back(0); pq.push_back(15'h11);
    dq.push_back(0); pq.push_back(15'h22);
    cyc(); empty = 0; out_ready = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin cyc(); #1; ok = out_valid; end
    checks++; if (!ok) $display("FAIL basic_timeout out_valid got 0 want 1"); else passed++;
    checks++; if (out_data !== {15'h22, 15'h11}) $display("FAIL basic_data got %h want %h", out_data, {15'h22, 15'h11}); else passed++;
    checks++; if (n_cons - n0 != 2) $display("FAIL basic_consumes got %0d want 2", n_cons - n0); else passed++;
`ifdef BUFFER_READER_PARITY_EN
    checks++; if (out_parity !== 1'b0) $display("FAIL basic_parity got %b want 0", out_parity); else passed++;
`endif
    drain();
  endtask

  task automatic test_drop();
    int n0;
    bit ok;
    logic [W-1:0] a, b;
    a = W'($urandom_range(1, 32767)); b = W'($urandom_range(1, 32767));
    n0 = n_cons;
    dq.push_back(0); pq.push_back(a);
    dq.push_back(WAIT_MAX); pq.push_back('0);
    dq.push_back(0); pq.push_back(b);
    cyc(); empty = 0;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin cyc(); #1; ok = (n_cons - n0 == 3); end
    checks++; if (!ok) $display("FAIL drop_timeout consumes got %0d want 3", n_cons - n0); else passed++;
    checks++; if (drop_cnt !== 8'd1) $display("FAIL drop_count got %0d want 1", drop_cnt); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL drop_no_valid got %b want 0", out_valid); else passed++;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin cyc(); #1; ok = out_valid; end
    checks++; if (out_data !== {b, a}) $display("FAIL drop_idx_kept got %h want %h", out_data, {b, a}); else passed++;
    checks++; if (drop_cnt !== 8'd1) $display("FAIL drop_count_hold got %0d want 1", drop_cnt); else passed++;
    drain();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [W-1:0] a, b;
    a = W'($urandom); b = W'($urandom);
    dq.push_back(0); pq.push_back(a);
    dq.push_back(0); pq.push_back(b);
    dq.push_back(WAIT_MAX); pq.push_back('0);
    cyc(); empty = 0; out_ready = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin cyc(); #1; ok = out_valid; end
    checks++; if (out_data !== {b, a}) $display("FAIL bp_data got %h want %h", out_data, {b, a}); else passed++;
    repeat (5) begin
      cyc(); #1;
      checks++; if (out_data !== {b, a}) $display("FAIL bp_stable got %h want %h", out_data, {b, a}); else passed++;
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid got %b want 1", out_valid); else passed++;
      checks++; if (consume !== 1'b0) $display("FAIL bp_consume_in_out got %b want 0", consume); else passed++;
    end
    cyc(); out_ready = 1; #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL bp_hs_valid got %b want 1", out_valid); else passed++;
    cyc(); out_ready = 0; #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_valid_drop got %b want 0", out_valid); else passed++;
    checks++; if (consume !== 1'b1) $display("FAIL bp_req_after_hs got %b want 1", consume); else passed++;
    cyc(); empty = 1;
    drain();
  endtask

  task automatic test_empty_hold();
    bit ok;
    logic [W-1:0] a, b;
    a = W'($urandom); b = W'($urandom);
    cyc(); empty = 1;
    repeat (10) begin
      cyc(); #1;
      checks++; if (consume !== 1'b0) $display("FAIL empty_consume got %b want 0", consume); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL empty_valid got %b want 0", out_valid); else passed++;
    end
    dq.push_back(2); pq.push_back(a);
    dq.push_back(0); pq.push_back(b);
    cyc(); empty = 0; #1;
    checks++; if (consume !== 1'b0) $display("FAIL empty_idle_first got %b want 0", consume); else passed++;
    cyc(); #1;
    checks++; if (consume !== 1'b1) $display("FAIL empty_req got %b want 1", consume); else passed++;
    cyc(); empty = 1;
    repeat (4) cyc();
    empty = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin cyc(); #1; ok = out_valid; end
    checks++; if (out_data !== {b, a}) $display("FAIL empty_rise_in_wait got %h want %h", out_data, {b, a}); else passed++;
    drain();
  endtask

  task automatic test_reset_midpack();
    bit ok;
    logic [W-1:0] a, b, c;
    a = W'($urandom_range(1, 32767)); b = W'($urandom); c = W'($urandom);
    dq.push_back(0); pq.push_back(a);
    cyc(); empty = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin cyc(); #1; ok = (lanes == 1); end
    empty = 1;
    #1 rst = 0;
    #1;
    checks++; if (consume !== 1'b0) $display("FAIL rstmid_consume got %b want 0", consume); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", out_valid); else passed++;
    checks++; if (out_data !== '0) $display("FAIL rstmid_data got %h want 0", out_data); else passed++;
    checks++; if (drop_cnt !== 8'd0) $display("FAIL rstmid_drop got %0d want 0", drop_cnt); else passed++;
    cyc(); rst = 1;
    dq.push_back(0); pq.push_back(b);
    dq.push_back(0); pq.push_back(c);
    empty = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin cyc(); #1; ok = out_valid; end
    checks++; if (out_data !== {c, b}) $display("FAIL rstmid_lane0 got %h want %h", out_data, {c, b}); else passed++;
    drain();
  endtask

  task automatic test_random();
    int w0;
    w0 = words_done;
    for (int i = 0; i < 800; i++) begin
      cyc();
      empty = ($urandom_range(0, 3) == 0);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++; if (out_valid !== exp_ov) $display("FAIL rnd_valid cycle %0d got %b want %b", i, out_valid, exp_ov); else passed++;
      if (exp_ov && exp_words.size() > 0) begin
        checks++; if (out_data !== exp_words[0]) $display("FAIL rnd_data cycle %0d got %h want %h", i, out_data, exp_words[0]); else passed++;
`ifdef BUFFER_READER_PARITY_EN
        checks++; if (out_parity !== ^exp_words[0]) $display("FAIL rnd_parity cycle %0d got %b want %b", i, out_parity, ^exp_words[0]); else passed++;
`endif
      end
      checks++; if (consume && (empty || act || exp_ov)) $display("FAIL rnd_consume cycle %0d got 1 want 0 (empty=%b wait=%b out=%b)", i, empty, act, exp_ov); else passed++;
      checks++; if (drop_cnt !== 8'(exp_drop)) $display("FAIL rnd_drop cycle %0d got %0d want %0d", i, drop_cnt, exp_drop); else passed++;
    end
    checks++; if (words_done - w0 < 10) $display("FAIL rnd_progress got %0d words want >= 10", words_done - w0); else passed++;
    drain();
  endtask

  task automatic test_saturate();
    int n0;
    bit ok;
    cyc(); rst = 0;
    cyc(); rst = 1; force_drop = 1; empty = 0; out_ready = 0;
    n0 = n_cons;
    ok = 0;
    for (int i = 0; i < 2500 && !ok; i++) begin cyc(); ok = (n_cons - n0 >= 260); end
    checks++; if (!ok) $display("FAIL sat_timeout consumes got %0d want 260", n_cons - n0); else passed++;
    empty = 1;
    repeat (6) cyc();
    #1;
    checks++; if (drop_cnt !== 8'd255) $display("FAIL sat_drop got %0d want 255", drop_cnt); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL sat_valid got %b want 0", out_valid); else passed++;
    force_drop = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop();
    test_backpressure();
    test_empty_hold();
    test_reset_midpack();
    test_random();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d checks passed so far", passed, checks);
    $fatal(1);
  end
endmodule
